// File: rtl/packed_linebuf_window.sv
// Streaming K-row column generator; the K-1 previous rows live packed LANES pixels per line-buffer word.
// Optional build macro LB_PRIME_ZERO_EN: zero the line buffers at frame start so every pixel yields a column.
module packed_linebuf_window #(
    parameter int PW    = 8,
    parameter int K     = 5,
    parameter int LANES = 4,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    localparam int XW   = $clog2(IMG_W),
    localparam int YW   = $clog2(IMG_H)
) (
    input  logic            CLK,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            complete,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PW-1:0]   in_pixel,
    output logic            col_valid,
    input  logic            col_ready,
    output logic [K*PW-1:0] col_data,
    output logic [XW-1:0]   col_x,
    output logic [YW-1:0]   col_y
);
    localparam int NB = (K - 1 + LANES - 1) / LANES;
    localparam int LW = LANES * PW;

    typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;

    logic [XW-1:0]    x;
    logic [YW-1:0]    y;
    logic             s1_valid;
    logic [PW-1:0]    s1_pixel;
    logic [XW-1:0]    s1_x;
    logic [YW-1:0]    s1_y;
    logic             s1_hold, accept, x_wrap, last_pixel;
    logic             wr_en;
    logic [XW-1:0]    wr_addr;
    logic [NB*LW-1:0] rd_flat, wr_flat, wr_data;

    assign x_wrap     = (x == XW'(IMG_W - 1));
    assign last_pixel = x_wrap && (y == YW'(IMG_H - 1));
    assign accept     = in_valid && in_ready;
    assign s1_hold    = col_valid && !col_ready;

`ifdef LB_PRIME_ZERO_EN
    assign col_valid = s1_valid;
`else
    // Warm-up rows still shift through the line buffers but never reach the output.
    assign col_valid = s1_valid && (s1_y >= YW'(K - 1));
`endif

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        complete = 1'b0;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef LB_PRIME_ZERO_EN
                    state_nx = CLEAR;
`else
                    state_nx = RUN;
`endif
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (x_wrap) state_nx = RUN;
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = !s1_hold;
                if (in_valid && !s1_hold && last_pixel) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!s1_hold) state_nx = DONE;
            end
            DONE: begin
                complete = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // x doubles as the clear address, so it is back at 0 when RUN begins.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (state == IDLE) begin
            x <= '0;
            y <= '0;
        end else if (state == CLEAR || accept) begin
            if (x_wrap) begin
                x <= '0;
                if (state != CLEAR) y <= last_pixel ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_pixel <= '0;
            s1_x     <= '0;
            s1_y     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_pixel <= in_pixel;
            s1_x     <= x;
            s1_y     <= y;
        end else if (!s1_hold) begin
            s1_valid <= 1'b0;
        end
    end

    // Write-back drops the oldest row and appends the current pixel; padding lanes stay zero.
    always_comb begin
        wr_flat = '0;
        for (int r = 0; r < K - 2; r++) wr_flat[r*PW +: PW] = rd_flat[(r+1)*PW +: PW];
        wr_flat[(K-2)*PW +: PW] = s1_pixel;
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = s1_x;
        wr_data = wr_flat;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = x;
            wr_data = '0;
        end else if (s1_valid && !s1_hold) begin
            wr_en = 1'b1;
        end
    end

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [LW-1:0] mem [IMG_W];
        logic [LW-1:0] rd_q;
        always_ff @(posedge CLK) begin
            if (wr_en)  mem[wr_addr] <= wr_data[b*LW +: LW];
            if (accept) rd_q <= mem[x];
        end
        assign rd_flat[b*LW +: LW] = rd_q;
    end

    assign col_data = s1_valid ? {s1_pixel, rd_flat[(K-1)*PW-1:0]} : '0;
    assign col_x    = s1_x;
    assign col_y    = s1_y;
endmodule

// File: tb/tb_packed_linebuf_window.sv
// Self-checking bench for packed_linebuf_window: scoreboarded frames, spot-check table, reset and stall cases.
module tb_packed_linebuf_window;
    localparam int PW    = 8;
    localparam int K     = 5;
    localparam int LANES = 4;
    localparam int IMG_W = 64;
    localparam int IMG_H = 64;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);
`ifdef LB_PRIME_ZERO_EN
    localparam bit PRIME = 1'b1;
`else
    localparam bit PRIME = 1'b0;
`endif
    localparam int COLS_PER_FRAME = PRIME ? IMG_W * IMG_H : (IMG_H - K + 1) * IMG_W;
    localparam int FIRST_READY    = PRIME ? IMG_W + 1 : 1;

    logic            CLK = 1'b0;
    logic            rst, start, in_valid, col_ready;
    logic [PW-1:0]   in_pixel;
    logic            busy, complete, in_ready, col_valid;
    logic [K*PW-1:0] col_data;
    logic [XW-1:0]   col_x;
    logic [YW-1:0]   col_y;

    packed_linebuf_window #(.PW(PW), .K(K), .LANES(LANES), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .CLK(CLK), .rst(rst), .start(start), .busy(busy), .complete(complete),
        .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
        .col_valid(col_valid), .col_ready(col_ready), .col_data(col_data),
        .col_x(col_x), .col_y(col_y)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [K*PW-1:0] data; int x; int y; } col_t;
    typedef struct { int x; int y; logic [K*PW-1:0] expected; } vec_t;

    col_t            sb[$];
    vec_t            vecs[6];
    logic [PW-1:0]   img [IMG_H][IMG_W];
    logic [K*PW-1:0] captured [IMG_H][IMG_W];
    int              checks = 0;
    int              errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic fillImage(input bit ramp);
        for (int yy = 0; yy < IMG_H; yy++)
            for (int xx = 0; xx < IMG_W; xx++) begin
                img[yy][xx]      = ramp ? PW'((xx + 16 * yy) & 8'hFF) : PW'($urandom);
                captured[yy][xx] = '0;
            end
    endtask

    task automatic checkTable();
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("table_col_%0d_%0d", vecs[i].x, vecs[i].y),
                        captured[vecs[i].y][vecs[i].x], vecs[i].expected);
    endtask

    // One frame: start pulse at cycle 0, random valid/ready, scoreboard on column handshakes.
    task automatic applyStimulus(input int readyPct, input int validPct, input int abortRow, input bit pokeStart);
        int   bx = 0, by = 0, colsSeen = 0, firstY = -1, firstReady = -1;
        int   lastHs = -10, completeCyc = -1, completes = 0;
        bit   allSent = 0, prevHold = 0, poked = 0, aborted = 0;
        logic [K*PW-1:0] heldData = '0;
        col_t e, got;
        sb.delete();
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge CLK);
            start     = (cyc == 0);
            if (pokeStart && !poked && by == 10 && bx == 5) begin
                start = 1'b1;
                poked = 1'b1;
            end
            col_ready = ($urandom_range(99) < readyPct);
            if (!allSent) begin
                in_valid = ($urandom_range(99) < validPct);
                in_pixel = img[by][bx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (firstReady < 0 && in_ready) firstReady = cyc;
            if (prevHold) begin
                checkOutput("hold_valid", col_valid, 1);
                checkOutput("hold_data", col_data, heldData);
            end
            if (col_valid && col_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_column", {col_y, col_x}, 0);
                end else begin
                    got = sb.pop_front();
                    checkOutput("col_data", col_data, got.data);
                    checkOutput("col_x", col_x, got.x);
                    checkOutput("col_y", col_y, got.y);
                end
                if (firstY < 0) firstY = col_y;
                captured[col_y][col_x] = col_data;
                colsSeen++;
                lastHs = cyc;
            end
            prevHold = col_valid && !col_ready;
            heldData = col_data;
            if (complete) begin
                completes++;
                if (completeCyc < 0) begin
                    completeCyc = cyc;
                    checkOutput("complete_after_last_col", cyc, lastHs + 1);
                    checkOutput("busy_low_at_complete", busy, 0);
                end
            end
            if (in_valid && in_ready) begin
                e.x = bx;
                e.y = by;
                e.data = '0;
                for (int r = 0; r < K; r++)
                    if (by - K + 1 + r >= 0) e.data[r*PW +: PW] = img[by-K+1+r][bx];
                if (PRIME || by >= K - 1) sb.push_back(e);
                if (bx == IMG_W - 1) begin
                    bx = 0;
                    if (by == IMG_H - 1) allSent = 1'b1;
                    else by++;
                end else begin
                    bx++;
                end
            end
            if (abortRow >= 0 && by == abortRow) begin
                aborted = 1'b1;
                break;
            end
            if (completeCyc >= 0 && cyc >= completeCyc + 4) break;
        end
        start = 1'b0;
        if (aborted) return;
        checkOutput("frame_completed", completeCyc >= 0, 1);
        checkOutput("complete_pulse_count", completes, 1);
        checkOutput("busy_idle_after_frame", busy, 0);
        checkOutput("column_count", colsSeen, COLS_PER_FRAME);
        checkOutput("first_col_y", firstY, PRIME ? 0 : K - 1);
        checkOutput("first_in_ready_cycle", firstReady, FIRST_READY);
        checkOutput("scoreboard_empty", sb.size(), 0);
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3, 6, 40'h6353433323};
        vecs[1] = '{0, 4, 40'h4030201000};
        vecs[2] = '{63, 4, 40'h7F6F5F4F3F};
        vecs[3] = '{10, 20, 40'h4A3A2A1A0A};
        vecs[4] = '{63, 63, 40'h2F1F0FFFEF};
        vecs[5] = '{5, 15, 40'hF5E5D5C5B5};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; col_ready = 1'b0; in_pixel = '0;
        repeat (3) @(negedge CLK);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_complete", complete, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_col_valid", col_valid, 0);
        checkOutput("reset_col_data", col_data, 0);
        checkOutput("reset_col_xy", {col_y, col_x}, 0);
        @(negedge CLK);
        rst = 1'b0;
        #1;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_in_ready", in_ready, 0);

        $display("[TB] frame 1: ramp, ready always, start poked mid-run");
        fillImage(1'b1);
        applyStimulus(100, 100, -1, 1'b1);
        checkTable();

        $display("[TB] frame 2: random pixels, 50%% col_ready, 80%% in_valid");
        fillImage(1'b0);
        applyStimulus(50, 80, -1, 1'b0);

        $display("[TB] frame 3: reset asserted at row 2");
        fillImage(1'b1);
        applyStimulus(100, 100, 2, 1'b0);
        checkOutput("pre_abort_busy", busy, 1);
        @(negedge CLK);
        rst = 1'b1;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_col_valid", col_valid, 0);
        checkOutput("abort_in_ready", in_ready, 0);
        checkOutput("abort_col_data", col_data, 0);
        checkOutput("abort_col_xy", {col_y, col_x}, 0);
        @(negedge CLK);
        rst = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        checkOutput("post_abort_idle_busy", busy, 0);
        checkOutput("post_abort_idle_ready", in_ready, 0);
        in_valid = 1'b0;

        $display("[TB] frame 4: ramp after abort, 70%% col_ready");
        fillImage(1'b1);
        applyStimulus(70, 100, -1, 1'b0);
        checkTable();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
